// File: rtl/mem_ctrl_pkg.sv
// Shared defines for mem_ctrl and the LSB: op codes, controller states and byte-count helper.
// Load result extension lives here too so both sides agree on LB/LH/LBU/LHU semantics.
package mem_ctrl_pkg;

  typedef logic [5:0] op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    STORE = 2'd3
  } state_t;

  localparam op_t OP_LB  = 6'd1;
  localparam op_t OP_LH  = 6'd2;
  localparam op_t OP_LW  = 6'd3;
  localparam op_t OP_LBU = 6'd4;
  localparam op_t OP_LHU = 6'd5;
  localparam op_t OP_SB  = 6'd6;
  localparam op_t OP_SH  = 6'd7;
  localparam op_t OP_SW  = 6'd8;

  function automatic logic [2:0] byte_count(input op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: byte_count = 3'd1;
      OP_LH, OP_LHU, OP_SH: byte_count = 3'd2;
      default:              byte_count = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input op_t op, input logic [31:0] w);
    case (op)
      OP_LB:   load_extend = {{24{w[7]}}, w[7:0]};
      OP_LBU:  load_extend = {24'h0, w[7:0]};
      OP_LH:   load_extend = {{16{w[15]}}, w[15:0]};
      OP_LHU:  load_extend = {16'h0, w[15:0]};
      default: load_extend = w;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-side signals of mem_ctrl; slave is the controller's view,
// master is the view of the fetch unit, LSB and RAM model driving it.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic        rdy;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        load_store_sgn;
  op_t         load_store_op;
  logic [31:0] load_store_addr;
  logic        begin_real_load;
  logic        mem_valid;
  logic [31:0] mem_res;
  logic        store_req;
  op_t         store_op;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic        finish_store;
  logic        rollback;

  modport slave (
    input  rdy, mem_din, io_buffer_full, if_req, if_addr,
           load_store_sgn, load_store_op, load_store_addr,
           store_req, store_op, store_addr, store_data, rollback,
    output mem_dout, mem_a, mem_wr, if_valid, if_inst,
           begin_real_load, mem_valid, mem_res, finish_store
  );

  modport master (
    output rdy, mem_din, io_buffer_full, if_req, if_addr,
           load_store_sgn, load_store_op, load_store_addr,
           store_req, store_op, store_addr, store_data, rollback,
    input  mem_dout, mem_a, mem_wr, if_valid, if_inst,
           begin_real_load, mem_valid, mem_res, finish_store
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial RAM arbiter (store > load > fetch); N-byte read completes N+1 cycles after acceptance.
// rdy=0 freezes everything; with IO_STALL_EN defined, I/O store bytes wait while io_buffer_full.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_IO = 32'h00030000
) (
  input  logic     clk,
  input  logic     rst,
  mem_ctrl_if.slave bus
);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_nxt;
  logic [2:0]  len_q;
  op_t         op_q;
  logic [31:0] mem_a_q;
  logic [7:0]  dout_q;
  logic        wr_q;
  logic [31:0] sdata_q;
  logic [31:0] rd_q;
  logic [31:0] word;
  logic        begin_q, mem_valid_q, if_valid_q, finish_q;
  logic [31:0] mem_res_q, if_inst_q;
  logic        acc_store, acc_load, acc_fetch;
  logic        last;
  logic        io_stall;

`ifdef IO_STALL_EN
  assign io_stall = (state_q == STORE) && bus.io_buffer_full && (mem_a_q >= ADDR_IO);
`else
  logic unused_io;
  assign unused_io = ^{bus.io_buffer_full, ADDR_IO};
  assign io_stall  = 1'b0;
`endif

  assign last    = ({1'b0, cnt_q} == (len_q - 3'd1));
  assign cnt_nxt = cnt_q + 2'd1;

  // The byte arriving this cycle merged over the bytes already collected.
  always_comb begin
    word = rd_q;
    word[8*cnt_q +: 8] = bus.mem_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    acc_store = 1'b0;
    acc_load  = 1'b0;
    acc_fetch = 1'b0;
    if (bus.rdy) begin
      case (state_q)
        IDLE: begin
          if (bus.store_req) begin
            acc_store = 1'b1;
            state_d   = STORE;
          end else if (!bus.rollback && bus.load_store_sgn) begin
            acc_load = 1'b1;
            state_d  = LOAD;
          end else if (!bus.rollback && bus.if_req) begin
            acc_fetch = 1'b1;
            state_d   = FETCH;
          end
        end
        FETCH, LOAD: if (bus.rollback || last) state_d = IDLE;
        STORE:       if (!io_stall && last)    state_d = IDLE;
        default:     state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= 2'd0;
      len_q       <= 3'd0;
      op_q        <= '0;
      mem_a_q     <= 32'h0;
      dout_q      <= 8'h0;
      wr_q        <= 1'b0;
      sdata_q     <= 32'h0;
      rd_q        <= 32'h0;
      begin_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
      finish_q    <= 1'b0;
      mem_res_q   <= 32'h0;
      if_inst_q   <= 32'h0;
    end else if (bus.rdy) begin
      begin_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
      finish_q    <= 1'b0;
      if (acc_store) begin
        mem_a_q <= bus.store_addr;
        dout_q  <= bus.store_data[7:0];
        sdata_q <= bus.store_data;
        wr_q    <= 1'b1;
        len_q   <= byte_count(bus.store_op);
        cnt_q   <= 2'd0;
      end else if (acc_load) begin
        mem_a_q <= bus.load_store_addr;
        op_q    <= bus.load_store_op;
        len_q   <= byte_count(bus.load_store_op);
        cnt_q   <= 2'd0;
        begin_q <= 1'b1;
      end else if (acc_fetch) begin
        mem_a_q <= bus.if_addr;
        len_q   <= 3'd4;
        cnt_q   <= 2'd0;
      end else begin
        case (state_q)
          LOAD, FETCH: begin
            if (!bus.rollback) begin
              rd_q    <= word;
              mem_a_q <= mem_a_q + 32'd1;
              cnt_q   <= cnt_nxt;
              if (last && state_q == LOAD) begin
                mem_valid_q <= 1'b1;
                mem_res_q   <= load_extend(op_q, word);
              end else if (last) begin
                if_valid_q <= 1'b1;
                if_inst_q  <= word;
              end
            end
          end
          STORE: begin
            if (!io_stall) begin
              if (last) begin
                wr_q     <= 1'b0;
                finish_q <= 1'b1;
              end else begin
                mem_a_q <= mem_a_q + 32'd1;
                cnt_q   <= cnt_nxt;
                dout_q  <= sdata_q[8*cnt_nxt +: 8];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Pulses are held in their registers while paused and masked on a same-cycle flush.
  assign bus.mem_wr          = wr_q & bus.rdy & ~io_stall;
  assign bus.mem_a           = mem_a_q;
  assign bus.mem_dout        = dout_q;
  assign bus.begin_real_load = begin_q & bus.rdy;
  assign bus.mem_valid       = mem_valid_q & bus.rdy & ~bus.rollback;
  assign bus.mem_res         = mem_res_q;
  assign bus.if_valid        = if_valid_q & bus.rdy & ~bus.rollback;
  assign bus.if_inst         = if_inst_q;
  assign bus.finish_store    = finish_q & bus.rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed-vector bench for mem_ctrl: a combinational-read RAM model answers mem_a,
// writes are logged per cycle, and pulse cycles are measured from the request cycle (cycle 0).
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk;
  logic rst;
  mem_ctrl_if bus ();

  logic [7:0]  ram [256];
  int          n_vec, n_err;
  int          t_brl, t_mv, t_iv, t_fs, n_mv, n_iv, n_fs, n_brl, nwr;
  logic [31:0] v_res, v_inst;
  logic [31:0] wr_a [8];
  logic [7:0]  wr_d [8];
  int          wr_c [8];
  logic        st_idle;

  mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  assign bus.mem_din = ram[bus.mem_a[7:0]];

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Steps n cycles after the request cycle, shaping rollback/rdy/io windows and logging events.
  task automatic run(input int n, input int roll_c, input int rdy_lo, input int rdy_hi,
                     input int io_lo, input int io_hi, input bit hold_if);
    t_brl = -1; t_mv = -1; t_iv = -1; t_fs = -1;
    n_mv = 0; n_iv = 0; n_fs = 0; n_brl = 0; nwr = 0; st_idle = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        bus.store_req      = 1'b0;
        bus.load_store_sgn = 1'b0;
        if (!hold_if) bus.if_req = 1'b0;
      end
      if (hold_if && t_fs > 0 && c == t_fs + 1) bus.if_req = 1'b0;
      bus.rollback       = (c == roll_c);
      bus.rdy            = !(c >= rdy_lo && c <= rdy_hi);
      bus.io_buffer_full = (c >= io_lo && c <= io_hi);
      #1;
      if (c == roll_c + 1) st_idle = (dut.state_q == IDLE);
      if (bus.begin_real_load) begin n_brl++; if (t_brl < 0) t_brl = c; end
      if (bus.mem_valid) begin n_mv++; if (t_mv < 0) begin t_mv = c; v_res = bus.mem_res; end end
      if (bus.if_valid) begin n_iv++; if (t_iv < 0) begin t_iv = c; v_inst = bus.if_inst; end end
      if (bus.finish_store) begin n_fs++; if (t_fs < 0) t_fs = c; end
      if (bus.mem_wr && nwr < 8) begin
        wr_a[nwr] = bus.mem_a;
        wr_d[nwr] = bus.mem_dout;
        wr_c[nwr] = c;
        nwr++;
      end
    end
    bus.rollback       = 1'b0;
    bus.rdy            = 1'b1;
    bus.io_buffer_full = 1'b0;
  endtask

  task automatic issue_load(input op_t op, input logic [31:0] a);
    bus.load_store_sgn  = 1'b1;
    bus.load_store_op   = op;
    bus.load_store_addr = a;
  endtask

  task automatic issue_store(input op_t op, input logic [31:0] a, input logic [31:0] d);
    bus.store_req  = 1'b1;
    bus.store_op   = op;
    bus.store_addr = a;
    bus.store_data = d;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus.rdy = 1'b1;
    bus.io_buffer_full = 1'b0;
    bus.if_req = 1'b0;
    bus.if_addr = 32'h0;
    bus.load_store_sgn = 1'b0;
    bus.load_store_op = '0;
    bus.load_store_addr = 32'h0;
    bus.store_req = 1'b0;
    bus.store_op = '0;
    bus.store_addr = 32'h0;
    bus.store_data = 32'h0;
    bus.rollback = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h00] = 8'h11; ram[8'h01] = 8'h22; ram[8'h02] = 8'h33; ram[8'h03] = 8'h44;
    ram[8'h04] = 8'h80; ram[8'h06] = 8'h34; ram[8'h07] = 8'h92;

    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_mem_wr",   32'(bus.mem_wr), 32'h0);
    check_vec("rst_mem_a",    bus.mem_a, 32'h0);
    check_vec("rst_mem_dout", 32'(bus.mem_dout), 32'h0);
    check_vec("rst_if_valid", 32'(bus.if_valid), 32'h0);
    check_vec("rst_if_inst",  bus.if_inst, 32'h0);
    check_vec("rst_brl",      32'(bus.begin_real_load), 32'h0);
    check_vec("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
    check_vec("rst_mem_res",  bus.mem_res, 32'h0);
    check_vec("rst_finish",   32'(bus.finish_store), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // LW 0x100, bytes 11 22 33 44
    issue_load(OP_LW, 32'h100);
    run(8, -1, -1, -1, -1, -1, 1'b0);
    check_vec("lw_brl_cyc",  t_brl, 1);
    check_vec("lw_brl_cnt",  n_brl, 1);
    check_vec("lw_valid_cyc", t_mv, 5);
    check_vec("lw_valid_cnt", n_mv, 1);
    check_vec("lw_res",      v_res, 32'h44332211);
    check_vec("lw_no_write", nwr, 0);

    issue_load(OP_LB, 32'h4);
    run(4, -1, -1, -1, -1, -1, 1'b0);
    check_vec("lb_valid_cyc", t_mv, 2);
    check_vec("lb_res",      v_res, 32'hFFFFFF80);

    issue_load(OP_LBU, 32'h4);
    run(4, -1, -1, -1, -1, -1, 1'b0);
    check_vec("lbu_res",     v_res, 32'h00000080);

    issue_load(OP_LH, 32'h6);
    run(5, -1, -1, -1, -1, -1, 1'b0);
    check_vec("lh_valid_cyc", t_mv, 3);
    check_vec("lh_res",      v_res, 32'hFFFF9234);

    issue_load(OP_LHU, 32'h6);
    run(5, -1, -1, -1, -1, -1, 1'b0);
    check_vec("lhu_res",     v_res, 32'h00009234);

    bus.if_req = 1'b1;
    bus.if_addr = 32'h100;
    run(7, -1, -1, -1, -1, -1, 1'b0);
    check_vec("fetch_valid_cyc", t_iv, 5);
    check_vec("fetch_inst",  v_inst, 32'h44332211);
    check_vec("fetch_no_brl", n_brl, 0);

    // SH across the top of the address space
    issue_store(OP_SH, 32'hFFFFFFFF, 32'h0000BEEF);
    run(5, -1, -1, -1, -1, -1, 1'b0);
    check_vec("sh_nwr",      nwr, 2);
    check_vec("sh_a0",       wr_a[0], 32'hFFFFFFFF);
    check_vec("sh_d0",       32'(wr_d[0]), 32'hEF);
    check_vec("sh_a1",       wr_a[1], 32'h0);
    check_vec("sh_d1",       32'(wr_d[1]), 32'hBE);
    check_vec("sh_finish_cyc", t_fs, 3);
    check_vec("sh_finish_cnt", n_fs, 1);

    // store and fetch together: store first, fetch taken in the finish_store cycle
    issue_store(OP_SW, 32'h10, 32'hDDCCBBAA);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h100;
    run(12, -1, -1, -1, -1, -1, 1'b1);
    check_vec("sw_nwr",      nwr, 4);
    check_vec("sw_a3",       wr_a[3], 32'h13);
    check_vec("sw_d3",       32'(wr_d[3]), 32'hDD);
    check_vec("sw_finish_cyc", t_fs, 5);
    check_vec("sw_fetch_cyc", t_iv, 10);
    check_vec("sw_fetch_inst", v_inst, 32'h44332211);

    issue_load(OP_LW, 32'h100);
    run(8, 3, -1, -1, -1, -1, 1'b0);
    check_vec("rb_lw_valid", n_mv, 0);
    check_vec("rb_lw_idle",  32'(st_idle), 32'h1);

    // rollback lands on the cycle the pulse would show
    issue_load(OP_LB, 32'h4);
    run(4, 2, -1, -1, -1, -1, 1'b0);
    check_vec("rb_pulse_valid", n_mv, 0);

    issue_load(OP_LW, 32'h100);
    bus.rollback = 1'b1;
    run(7, -1, -1, -1, -1, -1, 1'b0);
    check_vec("rb_idle_brl", n_brl, 0);
    check_vec("rb_idle_valid", n_mv, 0);

    issue_store(OP_SB, 32'h20, 32'h0000005A);
    bus.rollback = 1'b1;
    run(4, 1, -1, -1, -1, -1, 1'b0);
    check_vec("rb_sb_nwr",   nwr, 1);
    check_vec("rb_sb_d0",    32'(wr_d[0]), 32'h5A);
    check_vec("rb_sb_finish", t_fs, 2);

    issue_load(OP_LB, 32'h4);
    run(6, -1, 1, 2, -1, -1, 1'b0);
    check_vec("rdy_lb_brl",  t_brl, 3);
    check_vec("rdy_lb_valid", t_mv, 4);
    check_vec("rdy_lb_res",  v_res, 32'hFFFFFF80);

    issue_load(OP_LB, 32'h4);
    run(5, -1, 2, 2, -1, -1, 1'b0);
    check_vec("rdy_pulse_cyc", t_mv, 3);
    check_vec("rdy_pulse_cnt", n_mv, 1);

    issue_store(OP_SB, 32'h20, 32'h000000A5);
    run(6, -1, 1, 2, -1, -1, 1'b0);
    check_vec("rdy_sb_nwr",  nwr, 1);
    check_vec("rdy_sb_wcyc", wr_c[0], 3);
    check_vec("rdy_sb_finish", t_fs, 4);

    issue_store(OP_SB, 32'h00030000, 32'h00000077);
    run(7, -1, -1, -1, 1, 3, 1'b0);
    check_vec("io_sb_nwr",   nwr, 1);
    check_vec("io_sb_d0",    32'(wr_d[0]), 32'h77);
`ifdef IO_STALL_EN
    check_vec("io_sb_wcyc",  wr_c[0], 4);
    check_vec("io_sb_finish", t_fs, 5);
`else
    check_vec("io_sb_wcyc",  wr_c[0], 1);
    check_vec("io_sb_finish", t_fs, 2);
`endif

    issue_store(OP_SB, 32'h0002FFFF, 32'h00000066);
    run(5, -1, -1, -1, 1, 3, 1'b0);
    check_vec("lowio_sb_wcyc", wr_c[0], 1);
    check_vec("lowio_sb_finish", t_fs, 2);

    // reset in the middle of a load
    issue_load(OP_LW, 32'h100);
    run(2, -1, -1, -1, -1, -1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_vec("rstmid_mem_a", bus.mem_a, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(6, -1, -1, -1, -1, -1, 1'b0);
    check_vec("rstmid_valid", n_mv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_IO, default 32'h00030000, lowest memory-mapped I/O address.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rdy  input  1  global enable; low means pause.
REQ-005 SHALL have ports mem_din input 8 (RAM read byte), mem_dout output 8 (RAM write byte), mem_a output 32 (byte address), mem_wr output 1 (1 = write).
REQ-006 SHALL have port io_buffer_full  input  1  I/O sink cannot accept a byte.
REQ-007 SHALL have ports if_req input 1, if_addr input 32, if_valid output 1, if_inst output 32 for instruction fetch.
REQ-008 SHALL have ports load_store_sgn input 1, load_store_op input 6, load_store_addr input 32, begin_real_load output 1, mem_valid output 1, mem_res output 32 for LSB loads.
REQ-009 SHALL have ports store_req input 1, store_op input 6, store_addr input 32, store_data input 32, finish_store output 1 for committed stores.
REQ-010 SHALL have port rollback  input  1  mispredict flush.

Function
REQ-011 SHALL implement states IDLE, FETCH, LOAD, STORE.
REQ-012 In IDLE, SHALL accept one request per cycle, priority store_req > load_store_sgn > if_req.
REQ-013 Byte count SHALL be 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW, and 4 for fetch.
REQ-014 Reads SHALL drive mem_a = addr+k (mod 2^32) in the k-th cycle after acceptance, with mem_wr = 0; byte k SHALL be captured from mem_din one cycle later.
REQ-015 Bytes SHALL be assembled little-endian.
REQ-016 mem_valid or if_valid SHALL pulse for exactly one cycle, N+1 cycles after acceptance, with mem_res or if_inst stable during that pulse.
REQ-017 LB and LH SHALL sign-extend to 32 bits; LBU, LHU and LW SHALL zero-extend.
REQ-018 begin_real_load SHALL pulse for one cycle, in the cycle after a load is accepted.
REQ-019 Stores SHALL drive mem_wr = 1, mem_a = addr+k and mem_dout = store_data[8k+7:8k] for k = 0..N-1 on consecutive cycles.
REQ-020 finish_store SHALL pulse for one cycle, in the cycle after the last byte is written.
REQ-021 After a completion pulse, SHALL return to IDLE; a new request MAY be accepted in that same cycle.
REQ-022 rollback during FETCH or LOAD SHALL abort the transfer, go to IDLE next cycle, and produce no valid pulse, including when rollback coincides with the would-be pulse cycle.
REQ-023 rollback SHALL NOT affect STORE or finish_store.
REQ-024 rollback in IDLE SHALL suppress acceptance of load and fetch in that cycle; a store MAY still be accepted.
REQ-025 While rdy = 0, SHALL hold all state, keep mem_wr = 0, and issue no pulses.
REQ-026 When idle, mem_wr SHALL be 0.

Reset
REQ-027 On rst, SHALL enter IDLE immediately.
REQ-028 On rst, outputs SHALL be: mem_wr 0, mem_a 0, mem_dout 0, if_valid 0, if_inst 0, begin_real_load 0, mem_valid 0, mem_res 0, finish_store 0.
REQ-029 Reset mid-transfer SHALL discard the transfer with no completion pulse.

Configuration
REQ-030 With macro IO_STALL_EN defined, a STORE byte whose address is >= ADDR_IO SHALL be held (mem_wr 0, k not advanced) while io_buffer_full = 1.
REQ-031 With IO_STALL_EN undefined, io_buffer_full SHALL be ignored.

Structure
REQ-032 Op codes (LB, LH, LW, LBU, LHU, SB, SH, SW), the state encoding and the byte-count function SHALL live in the shared defines package, common with the LSB.
REQ-033 SHALL be a single module with no sub-modules.

Verification
REQ-034 LW at 0x100 with RAM bytes 11 22 33 44 -> begin_real_load at cycle 1, mem_valid at cycle 5, mem_res = 0x44332211.
REQ-035 LB at 0x4 with byte 0x80 -> mem_res = 0xFFFFFF80; LBU at 0x4 -> mem_res = 0x00000080.
REQ-036 SH at 0xFFFFFFFF with data 0xBEEF -> writes EF to 0xFFFFFFFF and BE to 0x0, then finish_store.
REQ-037 store_req and if_req asserted in the same cycle -> store served first, fetch accepted in the finish_store cycle.
REQ-038 rollback in cycle 3 of an LW -> no mem_valid, IDLE on the next cycle.
REQ-039 IO_STALL_EN defined, SB to 0x30000 with io_buffer_full high for 3 cycles -> write is delayed 3 cycles, then finish_store.
